// File: rtl/rx_slicer_pkg.sv
// Shared receive/transmit constants for the slicer and the transmit filter.
package rx_slicer_pkg;
  localparam int NB_DEF     = 8;
  localparam int NBF_DEF    = 7;
  localparam int OS_DEF     = 4;
  localparam int NB_CNT_DEF = 32;
  localparam int NB_DLY_DEF = 6;

  // Bit value carried by a negative symbol; must match the transmit mapper.
  localparam logic BIT_NEG = 1'b1;

  function automatic logic slice_sign(input logic sign);
    return sign ? BIT_NEG : ~BIT_NEG;
  endfunction
endpackage

// File: rtl/rx_slicer_ber_counter.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module ber_counter #(
  parameter int NB_CNT = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_inc,
  output logic [NB_CNT-1:0] o_count
);
  always_ff @(posedge clock) begin
    if (reset || i_clear)
      o_count <= '0;
    else if (i_inc && (o_count != {NB_CNT{1'b1}}))
      o_count <= o_count + 1'b1;
  end
endmodule

// File: rtl/rx_slicer.sv
// Decimating sign slicer with optional BER checker against a delayed reference.
// BER checking is built only when RX_SLICER_BER_CHECK_EN is defined.
module rx_slicer
  import rx_slicer_pkg::*;
#(
  parameter int NB     = NB_DEF,
  parameter int NBF    = NBF_DEF,
  parameter int OS     = OS_DEF,
  parameter int NB_CNT = NB_CNT_DEF,
  parameter int NB_DLY = NB_DLY_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NB-1:0]         i_data,
  input  logic                  i_enable,
  input  logic [$clog2(OS)-1:0] i_phase,
  input  logic                  i_ref_bit,
  input  logic                  i_ref_valid,
  input  logic [NB_DLY-1:0]     i_delay,
  input  logic                  i_clear,
  output logic                  o_bit,
  output logic                  o_valid,
  output logic [NB_CNT-1:0]     o_err_count,
  output logic [NB_CNT-1:0]     o_bit_count
);
  localparam int NB_PH = $clog2(OS);

  if (NBF >= NB) begin : g_bad_fmt
    $error("rx_slicer: NBF must be smaller than NB");
  end

  logic [NB_PH-1:0] phase;
  logic             event_hit;
  logic             det_bit;
  logic             unused_data;

  // Only the sign of the sample carries the decision.
  assign unused_data = ^i_data[NB-2:0];
  assign event_hit   = i_enable && (phase == i_phase);
  assign det_bit     = slice_sign(i_data[NB-1]);

  // OS is a power of two, so the counter wraps OS-1 -> 0 by overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase   <= '0;
      o_bit   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= event_hit;
      if (event_hit) o_bit <= det_bit;
      if (i_enable) phase <= phase + 1'b1;
    end
  end

`ifdef RX_SLICER_BER_CHECK_EN
  localparam int DEPTH = 2 ** NB_DLY;

  logic [DEPTH-1:0] dly;
  logic             ref_tap;
  logic             cnt_en;
  logic             err_en;

  // Tap is read before this cycle's shift, so a coincident strobe is not seen.
  assign ref_tap = dly[i_delay];
  assign cnt_en  = event_hit && !i_clear;
  assign err_en  = cnt_en && (det_bit != ref_tap);

  always_ff @(posedge clock) begin
    if (reset)
      dly <= '0;
    else if (i_ref_valid)
      dly <= {dly[DEPTH-2:0], i_ref_bit};
  end

  ber_counter #(.NB_CNT(NB_CNT)) u_bit_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_clear (i_clear),
    .i_inc   (cnt_en),
    .o_count (o_bit_count)
  );

  ber_counter #(.NB_CNT(NB_CNT)) u_err_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_clear (i_clear),
    .i_inc   (err_en),
    .o_count (o_err_count)
  );
`else
  logic unused_ref;

  assign unused_ref  = ^{i_ref_bit, i_ref_valid, i_delay, i_clear};
  assign o_err_count = '0;
  assign o_bit_count = '0;
`endif
endmodule
